// File: rtl/vedic_seq_mult8.sv
// Sequential 8x8 unsigned multiplier that reuses a single 4x4 Vedic multiplier over four nibble steps.
// Optional macro VEDIC_SEQ_ZERO_SKIP_EN: a zero operand goes straight to DONE without entering MUL.

module vedic_2x2 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] p
);
    logic c1;
    assign c1   = x[1] & y[0] & x[0] & y[1];
    assign p[0] = x[0] & y[0];
    assign p[1] = (x[1] & y[0]) ^ (x[0] & y[1]);
    assign p[2] = (x[1] & y[1]) ^ c1;
    assign p[3] = x[1] & y[1] & c1;
endmodule

module vedic_4x4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    logic [3:0] q0, q1, q2, q3;

    vedic_2x2 u_ll (.x(x[1:0]), .y(y[1:0]), .p(q0));
    vedic_2x2 u_hl (.x(x[3:2]), .y(y[1:0]), .p(q1));
    vedic_2x2 u_lh (.x(x[1:0]), .y(y[3:2]), .p(q2));
    vedic_2x2 u_hh (.x(x[3:2]), .y(y[3:2]), .p(q3));

    assign p = {4'b0, q0} + {2'b0, q1, 2'b0} + {2'b0, q2, 2'b0} + {q3, 4'b0};
endmodule

// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// MUL   | accumulating one nibble partial product per cycle, step 0..3
// DONE  | product presented on result with out_valid until out_ready
module vedic_seq_mult8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t      state;
    logic [1:0]  step;
    logic [7:0]  a_q, b_q;
    logic [15:0] acc;
    logic [3:0]  nib_a, nib_b;
    logic [7:0]  pp;
    logic [15:0] pp_sh, acc_next;

    // step[0] picks the high nibble of a, step[1] the high nibble of b
    assign nib_a = step[0] ? a_q[7:4] : a_q[3:0];
    assign nib_b = step[1] ? b_q[7:4] : b_q[3:0];

    vedic_4x4 u_mul (.x(nib_a), .y(nib_b), .p(pp));

    always_comb begin
        pp_sh = {8'h00, pp};
        case (step)
            2'd0:    pp_sh = {8'h00, pp};
            2'd1,
            2'd2:    pp_sh = {4'h0, pp, 4'h0};
            default: pp_sh = {pp, 8'h00};
        endcase
        acc_next = acc + pp_sh;
    end

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
    logic zero_op;
    assign zero_op = (a == 8'h00) || (b == 8'h00);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= 2'd0;
            acc       <= 16'h0000;
            a_q       <= 8'h00;
            b_q       <= 8'h00;
            result    <= 16'h0000;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        acc      <= 16'h0000;
                        step     <= 2'd0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
                        if (zero_op) begin
                            state     <= DONE;
                            result    <= 16'h0000;
                            out_valid <= 1'b1;
                        end else
`endif
                        state <= MUL;
                    end
                end
                MUL: begin
                    acc  <= acc_next;
                    step <= step + 2'd1;
                    if (step == 2'd3) begin
                        state     <= DONE;
                        result    <= acc_next;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vedic_seq_mult8.sv
// Directed bench for vedic_seq_mult8: reset, handshake, latency, stalls, abort and a randomized pair sweep.
// Honours VEDIC_SEQ_ZERO_SKIP_EN for the expected zero-operand latency.

module tb_vedic_seq_mult8;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready;
    logic [7:0]  a, b;
    logic        in_ready, out_valid, busy;
    logic [15:0] result;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [15:0] last_exp = 16'h0000;

    always #5 clk = ~clk;

    vedic_seq_mult8 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
        return (x == 8'h00 || y == 8'h00) ? 1 : 5;
`else
        return 5;
`endif
    endfunction

    // Called #1 after an edge with the block idle; returns #1 after the transfer edge.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic [15:0] exp, input int stall);
        int lat;
        a = ta; b = tb; in_valid = 1'b1; out_ready = 1'b0;
        chk("ready_before_accept", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        lat = 1;
        if (!out_valid) chk("result_hold_in_mul", result, last_exp);
        while (!out_valid && lat < 20) begin
            chk("busy_in_mul", busy, 1);
            chk("ready_low_in_mul", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, exp_lat(ta, tb));
        chk("result", result, exp);
        chk("busy_in_done", busy, 1);
        in_valid = 1'b1;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_result", result, exp);
            chk("stall_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("xfer_valid_drop", out_valid, 0);
        chk("xfer_ready", in_ready, 1);
        chk("xfer_busy", busy, 0);
        chk("xfer_result_kept", result, exp);
        last_exp = exp;
    endtask

    initial begin
        logic [7:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", result, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(8'hFF, 8'hFF, 16'hFE01, 0);
        do_op(8'h5A, 8'h3C, 16'h1518, 10);
        do_op(8'h12, 8'h34, 16'h03A8, 1);
        do_op(8'h00, 8'hAB, 16'h0000, 0);
        do_op(8'h80, 8'h80, 16'h4000, 2);
        do_op(8'hFF, 8'h00, 16'h0000, 1);
        do_op(8'h01, 8'hFF, 16'h00FF, 0);
        do_op(8'h0F, 8'hF0, 16'h0E10, 0);

        // Abort C3*7E while the FSM is in MUL step 2.
        a = 8'hC3; b = 8'h7E; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_in_mul", busy, 1);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b0;
        chk("abort_result", result, 16'h0000);
        chk("abort_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        for (int k = 0; k < 8; k++) begin
            chk("abort_no_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        last_exp = 16'h0000;
        do_op(8'h02, 8'h03, 16'h0006, 0);

        for (int i = 0; i < 1500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if (i % 50 == 0) ra = 8'h00;
            if (i % 77 == 0) rb = 8'h00;
            do_op(ra, rb, {8'h00, ra} * {8'h00, rb}, $urandom_range(0, 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
